// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory
// and buffers returned words with their PCs in a 2-entry queue for the decode register.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        InstrValidF
);

  // Handshake: a request transfers on a cycle where imem_req_valid & imem_req_ready.
  // Once raised, valid/addr stay stable until ready unless a redirect withdraws them.
  // Responses return in request order with no backpressure.

  logic [31:0] fetch_pc;
  logic [1:0]  outstanding;
  logic [1:0]  discard;
  logic [1:0]  count;

  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];
  logic        rd_ptr;
  logic        wr_ptr;

  logic [31:0] shadow_pc [2];
  logic        sh_rd;
  logic        sh_wr;

  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;
  logic        pop;
  logic        req_fire;
  logic        rsp_fire;
  logic        push;
  logic        drop;
  logic [2:0]  in_use;

  assign redirect   = (PCSrcE == 2'b01) | (PCSrcE == 2'b10);
  assign raw_target = (PCSrcE == 2'b10) ? (ALUResultE & 32'hFFFF_FFFE) : PCTargetE;
  assign target     = raw_target & 32'hFFFF_FFFC;

  assign InstrValidF = (count != 2'd0);
  assign pop         = InstrValidF & ~StallF & ~redirect;

  // Credit counts buffered words plus words in flight, including ones to be discarded.
  assign in_use         = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};
  assign imem_req_valid = ~reset & ~redirect & (in_use < 3'd2);
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_fire = imem_rsp_valid & (outstanding != 2'd0);
  assign push     = rsp_fire & (discard == 2'd0) & ~redirect;
  assign drop     = rsp_fire & (discard != 2'd0);

  assign InstrF   = InstrValidF ? fifo_instr[rd_ptr] : NOP_INSTR;
  assign PCF      = InstrValidF ? fifo_pc[rd_ptr] : 32'd0;
  assign PCPlus4F = PCF + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc      <= RESET_VECTOR;
      outstanding   <= 2'd0;
      discard       <= 2'd0;
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      sh_rd         <= 1'b0;
      sh_wr         <= 1'b0;
      fifo_instr[0] <= 32'd0;
      fifo_instr[1] <= 32'd0;
      fifo_pc[0]    <= 32'd0;
      fifo_pc[1]    <= 32'd0;
      shadow_pc[0]  <= 32'd0;
      shadow_pc[1]  <= 32'd0;
    end else begin
      // The shadow queue tracks every accepted request, kept or discarded alike.
      if (rsp_fire) begin
        sh_rd <= ~sh_rd;
      end
      if (req_fire) begin
        shadow_pc[sh_wr] <= fetch_pc;
        sh_wr            <= ~sh_wr;
      end

      if (redirect) begin
        count       <= 2'd0;
        rd_ptr      <= 1'b0;
        wr_ptr      <= 1'b0;
        fetch_pc    <= target;
        outstanding <= outstanding - {1'b0, rsp_fire};
        discard     <= outstanding - {1'b0, rsp_fire};
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        outstanding <= outstanding + {1'b0, req_fire} - {1'b0, rsp_fire};
        if (drop) begin
          discard <= discard - 2'd1;
        end
        if (push) begin
          fifo_instr[wr_ptr] <= imem_rsp_data;
          fifo_pc[wr_ptr]    <= shadow_pc[sh_rd];
          wr_ptr             <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized phase, all checked each
// cycle against a transaction-level model of the fetch queue and in-flight requests.
module tb_fetch_unit;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] KEY          = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        InstrValidF;

  fetch_unit #(
    .RESET_VECTOR(RESET_VECTOR),
    .NOP_INSTR   (NOP_INSTR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .PCSrcE        (PCSrcE),
    .PCTargetE     (PCTargetE),
    .ALUResultE    (ALUResultE),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .InstrF        (InstrF),
    .PCF           (PCF),
    .PCPlus4F      (PCPlus4F),
    .InstrValidF   (InstrValidF)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // ---------------- reference model ----------------
  // exp_q holds PCs of buffered words (instruction = pc ^ KEY); fl_* are accepted requests.
  logic [31:0] exp_q[$];
  logic [31:0] fl_pc_q[$];
  bit          fl_wrong_q[$];
  logic [31:0] model_pc;

  // ---------------- memory environment ----------------
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          mem_lat      = 1;
  bit          mem_rand_lat = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  task automatic drive_mem();
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_addr_q[0] ^ KEY;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance model and memory at the edge.
  task automatic tick();
    logic        redirect;
    logic        pop;
    logic        exp_req;
    logic        rsp_now;
    logic        req_acc;
    logic        rsp_take;
    logic        w;
    logic [31:0] tgt;
    logic [31:0] p;
    logic [31:0] exp_pc;
    logic [31:0] acc_addr;
    int          due;
    int          lat;
    #1;
    if (reset) begin
      exp_q.delete();
      fl_pc_q.delete();
      fl_wrong_q.delete();
      model_pc = RESET_VECTOR;
    end
    redirect = !reset && (PCSrcE == 2'b01 || PCSrcE == 2'b10);
    tgt      = (PCSrcE == 2'b10) ? ALUResultE : PCTargetE;
    tgt[1:0] = 2'b00;
    pop      = (exp_q.size() > 0) && !StallF && !redirect;
    exp_req  = !reset && !redirect && (fl_pc_q.size() + exp_q.size() - (pop ? 1 : 0) < 2);
    exp_pc   = (exp_q.size() > 0) ? exp_q[0] : 32'd0;

    check("instr_valid", {31'b0, InstrValidF}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
    check("pcf", PCF, exp_pc);
    check("instr", InstrF, (exp_q.size() > 0) ? (exp_q[0] ^ KEY) : NOP_INSTR);
    check("pcplus4", PCPlus4F, exp_pc + 32'd4);
    check("req_valid", {31'b0, imem_req_valid}, exp_req ? 32'd1 : 32'd0);
    if (exp_req) check("req_addr", imem_addr, model_pc);

    rsp_now  = imem_rsp_valid;
    req_acc  = imem_req_valid && imem_req_ready;
    acc_addr = imem_addr;
    @(posedge clk);

    if (rsp_now) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (req_acc) begin
      lat = mem_rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
      due = cycle + lat;
      if (mem_due_q.size() > 0 && due <= mem_due_q[$]) due = mem_due_q[$] + 1;
      mem_addr_q.push_back(acc_addr);
      mem_due_q.push_back(due);
    end

    if (!reset) begin
      rsp_take = rsp_now && (fl_pc_q.size() > 0);
      w        = 1'b0;
      p        = 32'd0;
      if (rsp_take) begin
        p = fl_pc_q.pop_front();
        w = fl_wrong_q.pop_front();
      end
      if (redirect) begin
        exp_q.delete();
        foreach (fl_wrong_q[i]) fl_wrong_q[i] = 1'b1;
        model_pc = tgt;
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (rsp_take && !w) exp_q.push_back(p);
        if (exp_req && imem_req_ready) begin
          fl_pc_q.push_back(model_pc);
          fl_wrong_q.push_back(1'b0);
          model_pc = model_pc + 32'd4;
        end
      end
    end
    cycle++;
    @(negedge clk);
    drive_mem();
  endtask

  task automatic wait_for_pc(input string tag, input logic [31:0] pc, input int budget);
    int n;
    n = 0;
    while (!(InstrValidF && PCF == pc) && n < budget) begin
      tick();
      n++;
    end
    check(tag, InstrValidF ? PCF : 32'hFFFF_FFFF, pc);
  endtask

  task automatic wait_two_inflight(input string tag, input bit need_rsp, input int budget);
    int n;
    n = 0;
    while (!(fl_pc_q.size() == 2 && (!need_rsp || imem_rsp_valid)) && n < budget) begin
      tick();
      n++;
    end
    check(tag, fl_pc_q.size(), 32'd2);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset          = 1'b1;
    StallF         = 1'b0;
    PCSrcE         = 2'b00;
    PCTargetE      = 32'd0;
    ALUResultE     = 32'd0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    model_pc       = RESET_VECTOR;
    @(negedge clk);

    // reset values, then streaming from RESET_VECTOR with a 1-cycle memory
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("stream_first_valid", {31'b0, InstrValidF}, 32'd1);
    check("stream_first_pc", PCF, RESET_VECTOR);
    check("stream_first_instr", InstrF, RESET_VECTOR ^ KEY);

    // stall at PC 0x10
    wait_for_pc("reach_0x10", 32'h10, 20);
    StallF = 1'b1;
    repeat (5) tick();
    check("stall_hold_pc", PCF, 32'h10);
    check("stall_hold_instr", InstrF, 32'h10 ^ KEY);
    StallF = 1'b0;
    tick();
    check("stall_resume_pc", PCF, 32'h14);
    repeat (6) tick();

    // branch redirect with two requests in flight
    mem_lat = 2;
    repeat (8) tick();
    wait_two_inflight("branch_setup", 1'b0, 20);
    PCSrcE    = 2'b01;
    PCTargetE = 32'h100;
    tick();
    PCSrcE = 2'b00;
    check("branch_valid_low", {31'b0, InstrValidF}, 32'd0);
    check("branch_new_addr", imem_addr, 32'h100);
    wait_for_pc("branch_first_pc", 32'h100, 20);
    repeat (4) tick();

    // jalr redirect: bit 0 cleared, then word aligned
    PCSrcE     = 2'b10;
    ALUResultE = 32'h203;
    tick();
    PCSrcE = 2'b00;
    check("jalr_addr", imem_addr, 32'h200);
    wait_for_pc("jalr_first_pc", 32'h200, 20);
    repeat (6) tick();

    // redirect coinciding with a response while the memory holds off
    wait_two_inflight("redir_rsp_setup", 1'b1, 20);
    PCSrcE         = 2'b01;
    PCTargetE      = 32'h300;
    imem_req_ready = 1'b0;
    tick();
    PCSrcE = 2'b00;
    repeat (3) begin
      check("hold_addr", imem_addr, 32'h300);
      tick();
    end
    imem_req_ready = 1'b1;
    wait_for_pc("redir_rsp_first_pc", 32'h300, 20);
    repeat (8) tick();

    // reset with two requests outstanding; stale responses land after deassert
    wait_two_inflight("reset_setup", 1'b1, 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    wait_for_pc("reset_restart_pc", RESET_VECTOR, 20);
    check("reset_restart_instr", InstrF, RESET_VECTOR ^ KEY);
    repeat (6) tick();

    // randomized phase
    mem_rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      StallF         = ($urandom_range(0, 3) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      PCSrcE         = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      PCTargetE      = $urandom;
      ALUResultE     = $urandom;
      tick();
    end
    StallF         = 1'b0;
    PCSrcE         = 2'b00;
    imem_req_ready = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
